// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
package ifu_fetch_ctrl_pkg;

  // Machine word / address width of the core.
  localparam int DATA_WIDTH = 32;

  // Width of one instruction word returned by instruction memory.
  localparam int INST_WIDTH = 32;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Byte distance between sequential fetches.
  localparam int INST_BYTES = 4;

  // What happens to an instruction-memory response in a given cycle.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,  // no response this cycle
    RSP_KEEP = 2'd1,  // correct-path response, goes to the output queue
    RSP_DROP = 2'd2   // wrong-path response, discarded
  } rsp_kind_e;

  // Occupancy counters need one bit more than the pointer width so that
  // a completely full structure (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. valid never depends combinationally on ready.
// valid is not sticky here: the fetch stage may drop imem_req_valid or
// id_valid without a transfer (e.g. on a redirect), so the receiver must not
// assume a raised valid holds. imem_rsp_valid has no ready; every response
// is consumed in the cycle it is presented, in request order.
interface ifu_fetch_ctrl_if
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DATA_WIDTH,
  parameter int IW         = INST_WIDTH
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [IW-1:0]         imem_rsp_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  id_valid;
  logic                  id_ready;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [IW-1:0]         id_inst;
  logic                  drop_pending;

  // Fetch stage side.
  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst, drop_pending,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
           redirect_pc, id_ready
  );

  // Environment side (memory, EX, ID).
  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst, drop_pending,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
           redirect_pc, id_ready
  );

endinterface

// File: rtl/ifu_fetch_ctrl_fetch_fifo.sv
// Small synchronous FIFO with flush; head is the registered oldest entry.
module ifu_fetch_ctrl_fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next pointers, count and storage; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count_q == FULL_CNT));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && count_q == '0));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch stage: owns the PC, issues in-order instruction-memory requests,
// queues returned instructions for decode and discards wrong-path responses
// that are still in flight after an EX redirect.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    DEPTH      = 4
) (
  input logic               clk,
  input logic               rst_n,
  ifu_fetch_ctrl_if.master  bus
);

  localparam int            CW      = cnt_width(DEPTH);
  localparam int            OW      = ADDR_WIDTH + INST_WIDTH;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic [CW-1:0]         pcq_count;
  logic [ADDR_WIDTH-1:0] pcq_head;
  logic [CW-1:0]         outq_count;
  logic [OW-1:0]         outq_head;

  logic [CW:0]           occupancy;
  logic                  credit_ok;
  logic                  req_valid;
  logic                  req_fire;
  logic                  id_valid;
  logic                  id_fire;
  logic                  has_head;
  rsp_kind_e             rsp_kind;

  // Issue credit and handshakes. Credit looks only at registered counts so a
  // slot freed by a pop this cycle is usable from the next cycle onwards.
  always_comb begin
    occupancy = {1'b0, inflight_q} + {1'b0, outq_count};
    credit_ok = occupancy < DEPTH_C;
    req_valid = rst_n && !bus.redirect_valid && credit_ok;
    req_fire  = req_valid && bus.imem_req_ready;
    id_valid  = rst_n && !bus.redirect_valid && (outq_count != '0);
    id_fire   = id_valid && bus.id_ready;
    has_head  = rst_n && (outq_count != '0);
  end

  // Classify this cycle's response: anything arriving under a redirect, or
  // while older wrong-path requests are outstanding, is thrown away.
  always_comb begin
    rsp_kind = RSP_NONE;
    if (bus.imem_rsp_valid) begin
      rsp_kind = (bus.redirect_valid || drop_q != '0) ? RSP_DROP : RSP_KEEP;
    end
  end

  // Next PC and counters. A redirect overrides everything: all requests still
  // outstanding after this cycle's response become wrong-path.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (bus.redirect_valid) begin
      pc_d       = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      inflight_d = inflight_q - CW'(bus.imem_rsp_valid);
      drop_d     = inflight_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
      end
      case ({req_fire, bus.imem_rsp_valid})
        2'b10:   inflight_d = inflight_q + 1'b1;
        2'b01:   inflight_d = inflight_q - 1'b1;
        default: inflight_d = inflight_q;
      endcase
      if (rsp_kind == RSP_DROP) begin
        drop_d = drop_q - 1'b1;
      end
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // PCs of correct-path requests still waiting for their response.
  ifu_fetch_ctrl_fetch_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_kind == RSP_KEEP),
    .flush     (bus.redirect_valid),
    .count     (pcq_count),
    .head      (pcq_head)
  );

  // Returned {pc, instruction} pairs waiting for decode.
  ifu_fetch_ctrl_fetch_fifo #(
    .WIDTH (OW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_kind == RSP_KEEP),
    .push_data ({pcq_head, bus.imem_rsp_data}),
    .pop       (id_fire),
    .flush     (bus.redirect_valid),
    .count     (outq_count),
    .head      (outq_head)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = id_valid;
  assign bus.id_pc          = has_head ? outq_head[OW-1:INST_WIDTH] : '0;
  assign bus.id_inst        = has_head ? outq_head[INST_WIDTH-1:0] : '0;
  assign bus.drop_pending   = rst_n && (drop_q != '0);

  // Every correct-path in-flight request has exactly one PC queue entry.
  a_pcq_tracks_inflight : assert property (@(posedge clk) disable iff (!rst_n)
    pcq_count == inflight_q - drop_q);

  a_rsp_has_request : assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> inflight_q != '0);

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for the fetch controller: in-order memory model with random latency
// and back-pressure, random redirects/resets, and a transaction-level model
// of which instructions must reach decode.
module tb_ifu_fetch_ctrl;
  import ifu_fetch_ctrl_pkg::*;

  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  ifu_fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (RPC),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- model state ----------------
  // One entry per accepted request, oldest first; live=0 means wrong-path.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          live;
  } req_t;

  req_t        req_q[$];
  logic [63:0] exp_q[$];   // {pc, inst} expected at decode, in order
  logic [31:0] m_pc;
  int          cyc;
  int          last_due;

  // stimulus knobs
  int          ready_pct;
  int          idr_pct;
  int          redir_pct;
  int          lat_min;
  int          lat_max;
  int          rst_pm;
  bit          force_rst;
  bit          force_redir;
  logic [31:0] force_pc;

  // last-cycle observations
  bit          o_req_valid;
  bit          o_req_fire;
  logic [31:0] o_req_addr;
  bit          o_id_valid;
  bit          o_id_fire;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_inst;
  bit          o_drop;

  int          n_checks;
  int          n_errors;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    bit          rsp;
    bit          redir;
    int          dead;
    int          due;
    logic [31:0] tgt;
    req_t        r;

    rst_n = !force_rst && !($urandom_range(0, 999) < rst_pm);
    bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    rsp = rst_n && (req_q.size() != 0) && (req_q[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? req_q[0].data : $urandom;
    redir = force_redir || ($urandom_range(0, 99) < redir_pct);
    tgt   = force_redir ? force_pc : {16'h8000, 16'($urandom)};
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.id_ready = ($urandom_range(0, 99) < idr_pct);

    @(negedge clk);
    o_req_valid = bus.imem_req_valid;
    o_req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    o_req_addr  = bus.imem_req_addr;
    o_id_valid  = bus.id_valid;
    o_id_fire   = bus.id_valid && bus.id_ready;
    o_id_pc     = bus.id_pc;
    o_id_inst   = bus.id_inst;
    o_drop      = bus.drop_pending;

    if (!rst_n) begin
      check("rst_req_valid", o_req_valid, 0);
      check("rst_id_valid", o_id_valid, 0);
      check("rst_drop_pending", o_drop, 0);
      check("rst_id_pc", o_id_pc, 0);
      check("rst_id_inst", o_id_inst, 0);
    end else begin
      dead = 0;
      foreach (req_q[i]) if (!req_q[i].live) dead++;
      check("req_valid", o_req_valid, !redir && (req_q.size() + exp_q.size() < DEPTH));
      if (o_req_valid) check("req_addr", o_req_addr, m_pc);
      check("id_valid", o_id_valid, !redir && (exp_q.size() != 0));
      if (o_id_valid && exp_q.size() != 0) check("id_head", {o_id_pc, o_id_inst}, exp_q[0]);
      check("drop_pending", o_drop, dead != 0);
    end

    @(posedge clk);
    if (!rst_n) begin
      req_q.delete();
      exp_q.delete();
      m_pc     = RPC;
      last_due = cyc;
    end else if (redir) begin
      if (rsp) void'(req_q.pop_front());
      exp_q.delete();
      foreach (req_q[i]) req_q[i].live = 1'b0;
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (o_id_fire && exp_q.size() != 0) void'(exp_q.pop_front());
      if (rsp) begin
        r = req_q.pop_front();
        if (r.live) exp_q.push_back({r.pc, r.data});
      end
      if (o_req_fire) begin
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        r.pc   = m_pc;
        r.data = $urandom;
        r.due  = due;
        r.live = 1'b1;
        req_q.push_back(r);
        last_due = due;
        m_pc     = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_knobs(input int rdy, input int idr, input int rd, input int lmin, input int lmax);
    ready_pct = rdy;
    idr_pct   = idr;
    redir_pct = rd;
    lat_min   = lmin;
    lat_max   = lmax;
  endtask

  task automatic do_reset(input int n);
    force_rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    force_rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1'b1;
    force_pc    = pc;
    step();
    force_redir = 1'b0;
  endtask

  // Step until decode sees an instruction; its PC must be exp_pc.
  task automatic expect_first_id(input string tag, input logic [31:0] exp_pc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (o_id_valid) begin
        check(tag, o_id_pc, exp_pc);
        found = 1'b1;
      end
    end
    if (!found) check({tag, "_timeout"}, 0, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int first_id;
    int fires;
    int bad;

    n_checks = 0; n_errors = 0; cyc = 0; last_due = 0; m_pc = RPC;
    rst_pm = 0; force_rst = 0; force_redir = 0; force_pc = '0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.id_ready = 0;

    // 1: streaming, 1-cycle memory, decode always ready
    set_knobs(100, 100, 0, 1, 1);
    do_reset(2);
    first_id = -1;
    fires    = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i < 3) check("t1_addr", o_req_addr, RPC + 32'(4 * i));
      if (o_id_valid && first_id < 0) first_id = i;
      if (o_id_fire) fires++;
    end
    check("t1_first_id_cycle", first_id, 2);
    check("t1_throughput", fires, 18);

    // 2: decode stalled -> exactly DEPTH requests, head held
    set_knobs(100, 0, 0, 1, 1);
    do_reset(1);
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_req_fire) fires++;
      if (o_id_valid) check("t2_head_pc", o_id_pc, RPC);
    end
    check("t2_req_count", fires, DEPTH);
    check("t2_req_valid_off", o_req_valid, 0);
    set_knobs(100, 100, 0, 1, 1);
    for (int i = 0; i < 10; i++) step();

    // 3: 3-cycle memory, redirect to unaligned target with 2 in flight
    set_knobs(100, 100, 0, 3, 3);
    do_reset(1);
    step();
    step();
    redirect_to(32'h8000_0101);
    step();
    check("t3_addr", o_req_addr, 32'h8000_0100);
    check("t3_drop_a", o_drop, 1);
    step();
    check("t3_drop_b", o_drop, 1);
    step();
    check("t3_drop_c", o_drop, 0);
    expect_first_id("t3_first_id_pc", 32'h8000_0100);

    // 4: redirect while a response and a decode handshake are present
    set_knobs(100, 100, 0, 1, 1);
    do_reset(1);
    for (int i = 0; i < 5; i++) step();
    redirect_to(32'h8000_3000);
    check("t4_id_valid", o_id_valid, 0);
    step();
    check("t4_drop", o_drop, 0);
    check("t4_addr", o_req_addr, 32'h8000_3000);
    expect_first_id("t4_first_id_pc", 32'h8000_3000);

    // 5: two redirects one cycle apart; only the second path reaches decode
    set_knobs(100, 100, 0, 3, 3);
    do_reset(1);
    for (int i = 0; i < 4; i++) step();
    redirect_to(32'h8000_1000);
    step();
    redirect_to(32'h8000_2000);
    bad = 0;
    first_id = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_id_valid && o_id_pc[31:12] == 20'h80001) bad++;
      if (o_id_valid && first_id == 0) begin
        check("t5_first_id_pc", o_id_pc, 32'h8000_2000);
        first_id = 1;
      end
    end
    check("t5_wrong_path_seen", bad, 0);
    check("t5_reached_id", first_id, 1);

    // 6: reset pulse mid-stream
    set_knobs(70, 70, 0, 1, 3);
    for (int i = 0; i < 30; i++) step();
    do_reset(1);
    check("t6_rst_id_valid", o_id_valid, 0);
    check("t6_rst_req_valid", o_req_valid, 0);
    step();
    check("t6_restart_valid", o_req_valid, 1);
    check("t6_restart_addr", o_req_addr, RPC);

    // random traffic with occasional redirects and resets
    rst_pm = 2;
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 8),
                1, $urandom_range(1, 4));
      for (int i = 0; i < 200; i++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
